noc_vc_link_arbiter: RTL

NOC_VC_LINK_ARBITER -- requirements
Module: noc_vc_link_arbiter

---
 rtl/noc_vc_link_arbiter_pkg.sv | 27 ++
 rtl/noc_vc_link_arbiter_rr_arbiter.sv | 29 ++
 rtl/noc_vc_link_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/noc_vc_link_arbiter_pkg.sv
// Shared NoC definitions: configuration record and flit type encodings
// used by the virtual-channel link arbiter and its testbench.
package optimsoc;

    // Network configuration record; only the fields the link arbiter needs.
    typedef struct packed {
        int unsigned NOC_VCHANNELS;
        int unsigned NOC_FLIT_WIDTH;
    } config_t;

    localparam config_t DEFAULT_CONFIG = '{
        NOC_VCHANNELS:  32'd3,
        NOC_FLIT_WIDTH: 32'd34
    };

    // Flit type field, carried in the two MSBs of every flit.
    localparam logic [1:0] PAYLOAD = 2'b00;
    localparam logic [1:0] HEADER  = 2'b01;
    localparam logic [1:0] LAST    = 2'b10;
    localparam logic [1:0] SINGLE  = 2'b11;

    // True for the flit types that close a packet and so release a VC lock.
    function automatic logic is_packet_end(input logic [1:0] flit_type);
        return (flit_type == LAST) || (flit_type == SINGLE);
    endfunction

endpackage

// File: rtl/noc_vc_link_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the last granted index, wrapping from N-1 back to 0.
module noc_rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan from last_ptr+1 around the ring and take the first request seen.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_vc_link_arbiter.sv
// Virtual-channel link arbiter: multiplexes per-VC flit streams onto one
// registered link stage. A VC keeps the link for up to MAX_BURST flits of a
// packet, then the grant rotates round-robin among VCs that have both a flit
// and downstream space.
module noc_vc_link_arbiter
    import optimsoc::*;
#(
    parameter config_t CONFIG    = DEFAULT_CONFIG,
    parameter int      MAX_BURST = 4,
    localparam int VCHANNELS  = int'(CONFIG.NOC_VCHANNELS),
    localparam int FLIT_WIDTH = int'(CONFIG.NOC_FLIT_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [VCHANNELS-1:0]                 in_valid,
    output logic [VCHANNELS-1:0]                 in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic [VCHANNELS-1:0]                 out_valid,
    input  logic [VCHANNELS-1:0]                 out_ready
);

    localparam int IDX_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Counter value of the final flit a locked VC may send before rotating.
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST - 1);
    // Pointer value after reset, so that VC0 is the first round-robin winner.
    localparam logic [IDX_W-1:0] PTR_RESET   = IDX_W'(VCHANNELS - 1);

    // Output stage and arbitration state.
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic [VCHANNELS-1:0]  out_valid_q, out_valid_d;
    logic                  lock_q, lock_d;
    logic [IDX_W-1:0]      lock_vc_q, lock_vc_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

    // Arbitration helpers.
    logic [VCHANNELS-1:0]  eligible;
    logic [VCHANNELS-1:0]  rr_gnt;
    logic [VCHANNELS-1:0]  lock_onehot;
    logic [VCHANNELS-1:0]  grant;
    logic                  loadable;
    logic                  keep_lock;
    logic                  in_xfer;
    logic [IDX_W-1:0]      grant_idx;
    logic [FLIT_WIDTH-1:0] grant_flit;
    logic [1:0]            grant_type;

    // A VC may compete only if it has a flit and the downstream VC has space.
    assign eligible = in_valid & out_ready;

    noc_rr_arbiter #(
        .N (VCHANNELS)
    ) u_rr_arbiter (
        .req      (eligible),
        .last_ptr (last_q),
        .gnt      (rr_gnt)
    );

    // Decide the grant: stay on the locked VC mid-burst, otherwise rotate.
    always_comb begin
        lock_onehot            = '0;
        lock_onehot[lock_vc_q] = 1'b1;
        loadable  = (out_valid_q == '0) || ((out_valid_q & out_ready) != '0);
        keep_lock = lock_q && eligible[lock_vc_q] && (burst_cnt_q < BURST_LIMIT);
        grant     = keep_lock ? lock_onehot : rr_gnt;
        in_ready  = (rst_n && loadable) ? grant : '0;
        in_xfer   = (in_ready != '0);
    end

    // Select the granted VC's flit and decode its type.
    always_comb begin
        grant_idx  = '0;
        grant_flit = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            if (grant[v]) begin
                grant_idx  = IDX_W'(v);
                grant_flit = in_flit[v];
            end
        end
        grant_type = grant_flit[FLIT_WIDTH-1 -: 2];
    end

    // Next state for the output register, lock, burst counter and pointer.
    always_comb begin
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        lock_d      = lock_q;
        lock_vc_d   = lock_vc_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;

        // The held flit leaves when its VC has space downstream.
        if ((out_valid_q & out_ready) != '0) begin
            out_valid_d = '0;
        end

        if (in_xfer) begin
            // A new flit replaces (or refills) the output register.
            out_flit_d  = grant_flit;
            out_valid_d = in_ready;
            last_d      = grant_idx;
            lock_vc_d   = grant_idx;
            lock_d      = !is_packet_end(grant_type);
            // Continuing a burst counts up; any rotation starts a new burst.
            burst_cnt_d = keep_lock ? (burst_cnt_q + 1'b1) : '0;
        end else if (lock_q && !eligible[lock_vc_q]) begin
            // The locked VC stalled; give up the lock so others may rotate in.
            lock_d      = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit_q  <= '0;
            out_valid_q <= '0;
            lock_q      <= 1'b0;
            lock_vc_q   <= '0;
            last_q      <= PTR_RESET;
            burst_cnt_q <= '0;
        end else begin
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            lock_q      <= lock_d;
            lock_vc_q   <= lock_vc_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;

endmodule
